// File: rtl/tl_a_arbiter.sv
// Round-robin arbiter sharing one TileLink A-channel queue enqueue port between N requesters.
// Multi-beat Put/Atomic messages hold the grant until their last beat is accepted.
module tl_a_arbiter #(
    parameter int N    = 3,
    parameter int IDXW = $clog2(N)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    input  logic [3*N-1:0]      in_opcode,
    input  logic [3*N-1:0]      in_param,
    input  logic [4*N-1:0]      in_size,
    input  logic [7*N-1:0]      in_source,
    input  logic [14*N-1:0]     in_address,
    input  logic [8*N-1:0]      in_mask,
    input  logic [N-1:0]        in_corrupt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_opcode,
    output logic [2:0]          out_param,
    output logic [3:0]          out_size,
    output logic [6:0]          out_source,
    output logic [13:0]         out_address,
    output logic [7:0]          out_mask,
    output logic                out_corrupt,
    output logic [IDXW-1:0]     grant_idx,
    output logic                locked
);

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_grant;
    logic [IDXW-1:0]   w_grant_nxt;
    logic [IDXW-1:0]   r_rr_ptr;
    logic [IDXW-1:0]   w_rr_nxt;
    logic [11:0]       r_cnt;
    logic [11:0]       w_cnt_nxt;

    logic [IDXW-1:0]   w_scan;
    logic              w_any;
    logic [IDXW-1:0]   w_grant;
    logic              w_fire;
    logic              w_multi;
    logic [12:0]       w_beats;
    logic [11:0]       w_cnt_init;

    function automatic logic [IDXW-1:0] f_next_idx(input logic [IDXW-1:0] idx);
        if (idx == IDXW'(N - 1)) begin
            return '0;
        end else begin
            return idx + IDXW'(1);
        end
    endfunction

    // Find the first valid requester scanning upward from rr_ptr; lowest offset wins.
    always_comb begin
        int v_idx;
        v_idx  = 0;
        w_scan = r_rr_ptr;
        w_any  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            v_idx  = (int'(r_rr_ptr) + k) % N;
            w_any  = w_any | in_valid[v_idx[IDXW-1:0]];
            w_scan = in_valid[v_idx[IDXW-1:0]] ? v_idx[IDXW-1:0] : w_scan;
        end
    end

    // Grant selection, zero-latency field mux and handshake.
    always_comb begin
        int v_g;
        w_grant     = (r_state == ST_FREE) ? w_scan : r_grant;
        v_g         = int'(w_grant);
        out_valid   = in_valid[w_grant];
        out_opcode  = in_opcode[3*v_g +: 3];
        out_param   = in_param[3*v_g +: 3];
        out_size    = in_size[4*v_g +: 4];
        out_source  = in_source[7*v_g +: 7];
        out_address = in_address[14*v_g +: 14];
        out_mask    = in_mask[8*v_g +: 8];
        out_corrupt = in_corrupt[w_grant];
        w_fire      = out_valid & out_ready;
        in_ready    = '0;
        in_ready[w_grant] = w_fire;
        grant_idx   = w_grant;
        locked      = (r_state == ST_BURST);
    end

    // Beat count of the presented first beat; 1 << 12 wraps to 0 so size 15 yields 4095 remaining.
    always_comb begin
        w_multi    = (out_opcode[2] == 1'b0) && (out_size > 4'd3);
        w_beats    = 13'd1 << (out_size - 4'd3);
        w_cnt_init = w_beats[11:0] - 12'd1;
    end

    // Next-state logic; a full queue only allows FREE to HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_FREE: begin
                if (w_any && !out_ready) begin
                    w_grant_nxt = w_grant;
                    w_state_nxt = ST_HOLD;
                end else if (w_fire && w_multi) begin
                    w_grant_nxt = w_grant;
                    w_cnt_nxt   = w_cnt_init;
                    w_state_nxt = ST_BURST;
                end else if (w_fire) begin
                    w_rr_nxt    = f_next_idx(w_grant);
                end else begin
                    w_state_nxt = ST_FREE;
                end
            end
            ST_HOLD: begin
                if (w_fire && w_multi) begin
                    w_cnt_nxt   = w_cnt_init;
                    w_state_nxt = ST_BURST;
                end else if (w_fire) begin
                    w_rr_nxt    = f_next_idx(r_grant);
                    w_state_nxt = ST_FREE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_BURST: begin
                if (w_fire) begin
                    w_cnt_nxt = r_cnt - 12'd1;
                    if (r_cnt == 12'd1) begin
                        w_rr_nxt    = f_next_idx(r_grant);
                        w_state_nxt = ST_FREE;
                    end else begin
                        w_state_nxt = ST_BURST;
                    end
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            default: begin
                w_state_nxt = ST_FREE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_FREE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= 12'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter (N=3): single beat, round-robin, burst lock, stall, bubble, reset.
module tb_tl_a_arbiter;

    localparam int N = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [2:0]     v = 3'b000;
    logic [2:0]     opc [0:2];
    logic [3:0]     sz [0:2];
    logic [13:0]    addr [0:2];
    logic [2:0]     in_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2:0]     out_opcode;
    logic [2:0]     out_param;
    logic [3:0]     out_size;
    logic [6:0]     out_source;
    logic [13:0]    out_address;
    logic [7:0]     out_mask;
    logic           out_corrupt;
    logic [1:0]     grant_idx;
    logic           locked;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tl_a_arbiter #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (v),
        .in_ready   (in_ready),
        .in_opcode  ({opc[2], opc[1], opc[0]}),
        .in_param   (9'd0),
        .in_size    ({sz[2], sz[1], sz[0]}),
        .in_source  ({7'd2, 7'd1, 7'd0}),
        .in_address ({addr[2], addr[1], addr[0]}),
        .in_mask    ({8'hFF, 8'hFF, 8'hFF}),
        .in_corrupt (3'b000),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_param  (out_param),
        .out_size   (out_size),
        .out_source (out_source),
        .out_address(out_address),
        .out_mask   (out_mask),
        .out_corrupt(out_corrupt),
        .grant_idx  (grant_idx),
        .locked     (locked)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 2 units after the edge, checks 1 unit later.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            opc[i]  = 3'd4;
            sz[i]   = 4'd3;
            addr[i] = 14'h0010 * 14'(i + 1);
        end
        step(); step();
        reset = 1'b0;
        settle();
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_in_ready",  16'(in_ready),  16'd0);
        chk("rst_grant",     16'(grant_idx), 16'd0);
        chk("rst_locked",    16'(locked),    16'd0);

        // Single beat Get from requester 1
        v = 3'b010; opc[1] = 3'd4; sz[1] = 4'd3; addr[1] = 14'h0100;
        settle();
        chk("t1_out_valid", 16'(out_valid),   16'd1);
        chk("t1_address",   16'(out_address), 16'h0100);
        chk("t1_in_ready",  16'(in_ready),    16'b010);
        chk("t1_source",    16'(out_source),  16'd1);
        step();
        v = 3'b000;
        settle();
        chk("t1_rr_ptr", 16'(grant_idx), 16'd2);
        chk("t1_idle",   16'(out_valid), 16'd0);

        // Round-robin from rr_ptr = 0
        reset = 1'b1; step(); reset = 1'b0;
        addr[0] = 14'h0A00; addr[1] = 14'h0B00; addr[2] = 14'h0C00;
        v = 3'b111;
        settle(); chk("rr_g0", 16'(grant_idx), 16'd0); chk("rr_a0", 16'(out_address), 16'h0A00);
        step(); settle(); chk("rr_g1", 16'(grant_idx), 16'd1); chk("rr_a1", 16'(out_address), 16'h0B00);
        step(); settle(); chk("rr_g2", 16'(grant_idx), 16'd2); chk("rr_r2", 16'(in_ready), 16'b100);
        step(); settle(); chk("rr_g3", 16'(grant_idx), 16'd0); chk("rr_r3", 16'(in_ready), 16'b001);
        step();
        v = 3'b000;

        // Burst lock: requester 0 PutFullData size 5 = 4 beats, requester 2 waiting
        reset = 1'b1; step(); reset = 1'b0;
        opc[0] = 3'd0; sz[0] = 4'd5;
        v = 3'b101;
        settle();
        chk("bl_b1_grant", 16'(grant_idx), 16'd0);
        chk("bl_b1_ready", 16'(in_ready),  16'b001);
        for (int b = 2; b <= 4; b++) begin
            step(); settle();
            chk($sformatf("bl_b%0d_grant", b),  16'(grant_idx), 16'd0);
            chk($sformatf("bl_b%0d_locked", b), 16'(locked),    16'd1);
            chk($sformatf("bl_b%0d_ready", b),  16'(in_ready),  16'b001);
        end
        step(); settle();
        chk("bl_5th_grant",  16'(grant_idx), 16'd2);
        chk("bl_5th_locked", 16'(locked),    16'd0);
        chk("bl_5th_ready",  16'(in_ready),  16'b100);
        step();
        v = 3'b000; opc[0] = 3'd4; sz[0] = 4'd3;

        // Stall hold: rr_ptr = 0, queue full
        out_ready = 1'b0;
        v = 3'b100;
        settle();
        chk("st_grant0", 16'(grant_idx), 16'd2);
        chk("st_valid0", 16'(out_valid), 16'd1);
        chk("st_ready0", 16'(in_ready),  16'd0);
        step();
        v = 3'b101;
        settle(); chk("st_grant1", 16'(grant_idx), 16'd2); chk("st_ready1", 16'(in_ready), 16'd0);
        step();
        settle(); chk("st_grant2", 16'(grant_idx), 16'd2);
        out_ready = 1'b1;
        settle(); chk("st_fire2", 16'(in_ready), 16'b100);
        step();
        v = 3'b001;
        settle(); chk("st_next", 16'(grant_idx), 16'd0); chk("st_next_rdy", 16'(in_ready), 16'b001);
        step();
        v = 3'b000;

        // Owner bubble: rr_ptr = 1, requester 2 PutPartialData size 4 = 2 beats
        opc[2] = 3'd1; sz[2] = 4'd4;
        v = 3'b100;
        settle(); chk("ob_b1_grant", 16'(grant_idx), 16'd2);
        step();
        v = 3'b010;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk($sformatf("ob_bub%0d_valid", c),  16'(out_valid), 16'd0);
            chk($sformatf("ob_bub%0d_ready", c),  16'(in_ready),  16'd0);
            chk($sformatf("ob_bub%0d_locked", c), 16'(locked),    16'd1);
            step();
        end
        v = 3'b110;
        settle();
        chk("ob_b2_ready",  16'(in_ready), 16'b100);
        chk("ob_b2_locked", 16'(locked),   16'd1);
        step();
        v = 3'b010;
        settle();
        chk("ob_done_locked", 16'(locked),    16'd0);
        chk("ob_done_grant",  16'(grant_idx), 16'd1);
        step();
        v = 3'b000; opc[2] = 3'd4; sz[2] = 4'd3;

        // Reset mid-burst after beat 2 of 4
        opc[0] = 3'd0; sz[0] = 4'd5;
        v = 3'b001;
        settle(); chk("rm_b1_grant", 16'(grant_idx), 16'd0);
        step(); step();
        settle(); chk("rm_locked_pre", 16'(locked), 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        v = 3'b000;
        settle();
        chk("rm_locked", 16'(locked),    16'd0);
        chk("rm_rr_ptr", 16'(grant_idx), 16'd0);
        chk("rm_valid",  16'(out_valid), 16'd0);
        v = 3'b110; opc[0] = 3'd4; sz[0] = 4'd3;
        settle();
        chk("rm_free_grant", 16'(grant_idx), 16'd1);
        chk("rm_free_ready", 16'(in_ready),  16'b010);
        step();
        v = 3'b000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Round-robin arbiter that shares one TileLink A-channel beat queue (2-entry, 8-byte beat, 14-bit address) between N requesters.
- Drives the queue's enqueue interface directly.
- Keeps multi-beat data messages (Put/Atomic with size > 3) atomic: once a message's first beat is accepted, no other requester can interleave beats until the last beat is accepted.
- Sits between the per-client A-channel sources and the shared queue.

Parameters:
- N, 3, number of requesters (2..8).
- IDXW, $clog2(N), width of the grant index.

Ports:
- clock  in  1  clock; reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  N  per-requester valid.
- in_ready  out  N  per-requester ready.
- in_opcode  in  3*N  packed, requester i at [3i+2:3i].
- in_param  in  3*N  packed.
- in_size  in  4*N  packed, log2 bytes.
- in_source  in  7*N  packed.
- in_address  in  14*N  packed.
- in_mask  in  8*N  packed.
- in_corrupt  in  N  packed.
- out_valid  out  1  to queue enq valid.
- out_ready  in  1  from queue enq ready.
- out_opcode, out_param, out_size, out_source, out_address, out_mask, out_corrupt  out  3,3,4,7,14,8,1  muxed fields of the granted requester.
- grant_idx  out  IDXW  currently selected requester.
- locked  out  1  high while a multi-beat message is in flight.

Behaviour:
- fire = out_valid & out_ready.
- Data opcodes: 0, 1, 2, 3.
- beats = data opcode && size > 3 ? 2^(size-3) : 1.
- Beat counter is 12 bits wide; size 15 gives 4096 beats.
- State machine:
  - FREE: grant_idx is combinational; it is the first valid requester found scanning up from rr_ptr, modulo N.
  - HOLD: grant_idx is frozen.
  - BURST: grant_idx is frozen and locked = 1.
- FREE transitions:
  - No valid requester: out_valid = 0 and grant_idx = rr_ptr.
  - A valid requester exists and out_ready = 0: register grant, go to HOLD. out_valid must not change source while stalled.
  - Fire with beats == 1: rr_ptr <= winner+1 (mod N), stay FREE.
  - Fire with beats > 1: register grant, cnt <= beats-1, go to BURST.
- HOLD transitions:
  - Fire with beats == 1: rr_ptr <= grant+1, go to FREE.
  - Fire with beats > 1: cnt <= beats-1, go to BURST.
- BURST transitions:
  - Each fire decrements cnt.
  - Fire with cnt == 1: rr_ptr <= grant+1, go to FREE.
  - out_valid = in_valid[grant]. Bubbles from the owner are allowed, and other requesters stay blocked during them.
- Handshake signals:
  - out_valid = in_valid[grant_idx] (in FREE: any valid).
  - in_ready[i] = out_ready & out_valid & (grant_idx == i).
  - All other in_ready bits are 0.
  - Output data is a zero-latency combinational mux. There are no storage registers beyond state, grant, rr_ptr and cnt.
- Arbitration fairness: a requester that wins will not win again until every other requester that was continuously valid has been granted. The latency bound is N messages.
- Requesters must keep valid and fields stable until accepted. The arbiter does not check this.
- Beat count comes from the first beat's opcode and size. Later beats' opcode and size are passed through unchanged but ignored.
- Reset:
  - State = FREE, rr_ptr = 0, cnt = 0, locked = 0.
  - With all in_valid low, out_valid = 0, in_ready = 0 and grant_idx = 0.
- Reset mid-burst: the burst is abandoned at once. The next cycle follows the reset arbitration rules. Recovering the downstream queue is the system's responsibility, because reset is shared.
- Queue full (out_ready = 0) in any state: no state change except FREE to HOLD.

Test Plan:
- Single beat, idle queue: reset, then requester 1 valid with opcode 4 (Get), size 3, address 0x0100. Required: same cycle out_valid = 1, out_address = 0x0100, in_ready = 3'b010, then rr_ptr = 2.
- Round-robin: all 3 requesters hold Gets, out_ready = 1. Required: grants in order 0, 1, 2, 0, one per cycle.
- Burst lock: requester 0 sends PutFullData size 5 (4 beats) while requester 2 is valid. Required: 4 consecutive grants to 0 with locked = 1, then requester 2 on the 5th fire.
- Stall hold: queue full (out_ready = 0), requester 2 valid, then requester 0 asserts valid. Required: grant_idx stays 2 until out_ready rises, and requester 2 fires first.
- Owner bubble: during a size-4 burst, the owner deasserts valid for 2 cycles while requester 1 is valid. Required: out_valid = 0, in_ready[1] = 0, and the burst completes on its 2nd beat.
- Reset mid-burst: reset asserted after beat 2 of 4. Required: next cycle locked = 0, state FREE, rr_ptr = 0.
